// File: rtl/aes_bus_sequencer_if.sv
// Client key/block/result handshakes, status flags and the AES core register bus.
// valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
// the sender holds valid and its payload stable until that edge, and ready may depend on valid.
interface aes_bus_sequencer_if;
   logic         key_valid;
   logic         key_ready;
   logic [255:0] key;
   logic         keylen;
   logic         blk_valid;
   logic         blk_ready;
   logic [127:0] blk_data;
   logic         encdec;
   logic         res_valid;
   logic         res_ready;
   logic [127:0] res_data;
   logic         key_loaded;
   logic         busy;
   logic         err;
   logic         cs;
   logic         we;
   logic [7:0]   address;
   logic [31:0]  write_data;
   logic [31:0]  read_data;
   logic         error;

   modport master (
      input  key_valid, key, keylen, blk_valid, blk_data, encdec, res_ready, read_data, error,
      output key_ready, blk_ready, res_valid, res_data, key_loaded, busy, err,
             cs, we, address, write_data
   );

   modport slave (
      output key_valid, key, keylen, blk_valid, blk_data, encdec, res_ready, read_data, error,
      input  key_ready, blk_ready, res_valid, res_data, key_loaded, busy, err,
             cs, we, address, write_data
   );
endinterface

// File: rtl/aes_bus_sequencer.sv
// Bus master that loads a key into the AES core and then streams 128-bit blocks
// through its register port, returning each result on a valid/ready handshake.
module aes_bus_sequencer #(
   parameter int POLL_DELAY = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic                clk,
   input  logic                reset_n,
   aes_bus_sequencer_if.master bus,
   output logic [3:0]          state_dbg
);

   typedef enum logic [3:0] {
      IDLE, KEY_WR, KEY_WAIT, KEY_POLL, BLK_WR, BLK_WAIT, BLK_POLL, RD, OUT
   } state_t;

   localparam logic [7:0] ADDR_CTRL   = 8'h08;
   localparam logic [7:0] ADDR_CONFIG = 8'h09;
   localparam logic [7:0] ADDR_STATUS = 8'h0a;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int DW = (POLL_DELAY > 1) ? $clog2(POLL_DELAY) : 1;
   localparam logic [TW-1:0] POLL_LAST = TW'(TIMEOUT);
   localparam logic [DW-1:0] WAIT_LAST = DW'(POLL_DELAY - 1);

   state_t          state;
   logic [3:0]      idx;
   logic [DW-1:0]   wait_cnt;
   logic [TW-1:0]   poll_cnt;
   logic [255:0]    key_q;
   logic            keylen_q;
   logic [127:0]    blk_q;
   logic            encdec_q;
   logic            cs_q;
   logic            we_q;
   logic [7:0]      addr_q;
   logic [31:0]     wdata_q;
   logic            res_valid_q;
   logic [127:0]    res_q;
   logic            key_loaded_q;
   logic            err_q;

   logic [31:0]     key_w [8];
   logic [31:0]     blk_w [4];
   logic [7:0]      wr_addr;
   logic [31:0]     wr_data;
   logic            last_wr;
   logic            status_hit;

   always_comb begin
      for (int i = 0; i < 8; i++) key_w[i] = key_q[255 - 32*i -: 32];
      for (int i = 0; i < 4; i++) blk_w[i] = blk_q[127 - 32*i -: 32];
   end

   // Write sequence for the current step: data words, then CONFIG, then CTRL.
   always_comb begin
      wr_addr = ADDR_CTRL;
      wr_data = 32'h0;
      last_wr = 1'b0;
      if (state == KEY_WR) begin
         last_wr = (idx == 4'd10);
         if (idx < 4'd8) begin
            wr_addr = {5'b00010, idx[2:0]};
            wr_data = key_w[idx[2:0]];
         end else if (idx == 4'd8) begin
            wr_addr = ADDR_CONFIG;
            wr_data = {30'h0, keylen_q, 1'b0};
         end else begin
            wr_data = 32'h1;
         end
      end else begin
         last_wr = (idx == 4'd6);
         if (idx < 4'd4) begin
            wr_addr = {6'b001000, idx[1:0]};
            wr_data = blk_w[idx[1:0]];
         end else if (idx == 4'd4) begin
            wr_addr = ADDR_CONFIG;
            wr_data = {30'h0, keylen_q, encdec_q};
         end else begin
            wr_data = 32'h2;
         end
      end
   end

   assign status_hit = (state == KEY_POLL) ? bus.read_data[0] : bus.read_data[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         idx          <= 4'd0;
         wait_cnt     <= '0;
         poll_cnt     <= '0;
         key_q        <= 256'h0;
         keylen_q     <= 1'b0;
         blk_q        <= 128'h0;
         encdec_q     <= 1'b0;
         cs_q         <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 8'h0;
         wdata_q      <= 32'h0;
         res_valid_q  <= 1'b0;
         res_q        <= 128'h0;
         key_loaded_q <= 1'b0;
         err_q        <= 1'b0;
      end else if (cs_q && bus.error) begin
         // Abort on any core access error; key_loaded is already 0 during a key load.
         state <= IDLE;
         cs_q  <= 1'b0;
         we_q  <= 1'b0;
         err_q <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.key_valid) begin
                  key_q        <= bus.key;
                  keylen_q     <= bus.keylen;
                  err_q        <= 1'b0;
                  key_loaded_q <= 1'b0;
                  idx          <= 4'd0;
                  state        <= KEY_WR;
               end else if (bus.blk_valid && key_loaded_q) begin
                  blk_q    <= bus.blk_data;
                  encdec_q <= bus.encdec;
                  idx      <= 4'd0;
                  state    <= BLK_WR;
               end
            end
            KEY_WR, BLK_WR: begin
               if (!last_wr) begin
                  cs_q    <= 1'b1;
                  we_q    <= 1'b1;
                  addr_q  <= wr_addr;
                  wdata_q <= wr_data;
                  idx     <= idx + 4'd1;
               end else if (POLL_DELAY == 0) begin
                  cs_q     <= 1'b1;
                  we_q     <= 1'b0;
                  addr_q   <= ADDR_STATUS;
                  poll_cnt <= TW'(1);
                  state    <= (state == KEY_WR) ? KEY_POLL : BLK_POLL;
               end else begin
                  cs_q     <= 1'b0;
                  we_q     <= 1'b0;
                  wait_cnt <= '0;
                  state    <= (state == KEY_WR) ? KEY_WAIT : BLK_WAIT;
               end
            end
            KEY_WAIT, BLK_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  cs_q     <= 1'b1;
                  we_q     <= 1'b0;
                  addr_q   <= ADDR_STATUS;
                  poll_cnt <= TW'(1);
                  state    <= (state == KEY_WAIT) ? KEY_POLL : BLK_POLL;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            KEY_POLL, BLK_POLL: begin
               // One STATUS read per cycle; poll_cnt counts reads issued in this phase.
               if (status_hit) begin
                  if (state == KEY_POLL) begin
                     cs_q         <= 1'b0;
                     key_loaded_q <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     addr_q <= 8'h30;
                     idx    <= 4'd0;
                     state  <= RD;
                  end
               end else if (poll_cnt == POLL_LAST) begin
                  cs_q  <= 1'b0;
                  err_q <= 1'b1;
                  state <= IDLE;
               end else begin
                  poll_cnt <= poll_cnt + 1'b1;
               end
            end
            RD: begin
               case (idx[1:0])
                  2'd0:    res_q[127:96] <= bus.read_data;
                  2'd1:    res_q[95:64]  <= bus.read_data;
                  2'd2:    res_q[63:32]  <= bus.read_data;
                  default: res_q[31:0]   <= bus.read_data;
               endcase
               if (idx[1:0] == 2'd3) begin
                  cs_q        <= 1'b0;
                  res_valid_q <= 1'b1;
                  state       <= OUT;
               end else begin
                  idx    <= idx + 4'd1;
                  addr_q <= {6'b001100, idx[1:0] + 2'd1};
               end
            end
            OUT: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.key_ready  = (state == IDLE);
   assign bus.blk_ready  = (state == IDLE) && key_loaded_q && !bus.key_valid;
   assign bus.busy       = (state != IDLE);
   assign bus.res_valid  = res_valid_q;
   assign bus.res_data   = res_q;
   assign bus.key_loaded = key_loaded_q;
   assign bus.err        = err_q;
   assign bus.cs         = cs_q;
   assign bus.we         = we_q;
   assign bus.address    = addr_q;
   assign bus.write_data = wdata_q;
   assign state_dbg      = state;

endmodule
